// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dq_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so the shifted remainder needs one extra bit
    // and the trial difference always fits in WIDTH+1 signed bits.
    always_comb begin
        rem_sh = {rem_i, dq_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            dq_o  = {dq_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            dq_o  = {dq_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned integer divider (DIV/DIVU/REM/REMU) with
// start/busy/valid handshake, flush, and a fast path for x/0 and MIN/-1.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             op_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]  MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dq;
    logic             dvd_neg;
    logic             dvs_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dq_i      (dq_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .dq_o      (step_dq)
    );

    assign dvd_neg = op_signed_i & dividend_i[WIDTH-1];
    assign dvs_neg = op_signed_i & divisor_i[WIDTH-1];

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dq_d       = dq_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dbz_pend_d = dbz_pend_q;
        valid_d    = 1'b0;
        quot_d     = quot_q;
        remo_d     = remo_q;
        dbz_d      = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    q_neg_d = 1'b0;
                    r_neg_d = 1'b0;
                    state_d = DONE;
                    if (divisor_i == '0) begin
                        dq_d       = '1;
                        rem_d      = dividend_i;
                        dvs_d      = divisor_i;
                        dbz_pend_d = 1'b1;
                    end else if (op_signed_i && dividend_i == MIN_VAL && divisor_i == '1) begin
                        dq_d       = MIN_VAL;
                        rem_d      = '0;
                        dvs_d      = divisor_i;
                        dbz_pend_d = 1'b0;
                    end else begin
                        dq_d       = dvd_neg ? -dividend_i : dividend_i;
                        dvs_d      = dvs_neg ? -divisor_i  : divisor_i;
                        rem_d      = '0;
                        q_neg_d    = dvd_neg ^ dvs_neg;
                        r_neg_d    = dvd_neg;
                        cnt_d      = CNT_INIT;
                        dbz_pend_d = 1'b0;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    dq_d  = step_dq;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    dq_d    = q_neg_q ? -dq_q  : dq_q;
                    rem_d   = r_neg_q ? -rem_q : rem_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                quot_d  = dq_q;
                remo_d  = rem_q;
                dbz_d   = dbz_pend_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            dq_q       <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dbz_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            quot_q     <= '0;
            remo_q     <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dq_q       <= dq_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dbz_pend_q <= dbz_pend_d;
            valid_q    <= valid_d;
            quot_q     <= quot_d;
            remo_q     <= remo_d;
            dbz_q      <= dbz_d;
        end
    end

    // Busy covers the result-staging DONE cycle; it drops on the valid edge.
    assign busy_o        = (state_q != IDLE);
    assign valid_o       = valid_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = remo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit at WIDTH=32 and WIDTH=8.
module tb_div_unit;

    logic        clk;
    logic        rst_n;

    logic        start32, flush32, sgn32;
    logic [31:0] a32, b32;
    logic        busy32, valid32, dbz32;
    logic [31:0] q32, r32;

    logic        start8, flush8, sgn8;
    logic [7:0]  a8, b8;
    logic        busy8, valid8, dbz8;
    logic [7:0]  q8, r8;

    int n_cmp;
    int n_bad;

    div_unit #(.WIDTH(32)) dut32 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start32),
        .flush_i       (flush32),
        .op_signed_i   (sgn32),
        .dividend_i    (a32),
        .divisor_i     (b32),
        .busy_o        (busy32),
        .valid_o       (valid32),
        .quotient_o    (q32),
        .remainder_o   (r32),
        .div_by_zero_o (dbz32)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start8),
        .flush_i       (flush8),
        .op_signed_i   (sgn8),
        .dividend_i    (a8),
        .divisor_i     (b8),
        .busy_o        (busy8),
        .valid_o       (valid8),
        .quotient_o    (q8),
        .remainder_o   (r8),
        .div_by_zero_o (dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a 32-bit op at E0 and returns the number of edges after E0 until valid.
    task automatic applyStimulus32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output int edges, output logic busy_ok);
        sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        busy_ok = busy32;
        edges = 0;
        while (!valid32 && edges < 60) begin
            tick();
            edges++;
            if (!valid32 && !busy32) busy_ok = 1'b0;
        end
    endtask

    task automatic applyStimulus8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                                  output int edges, output logic busy_ok);
        sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        busy_ok = busy8;
        edges = 0;
        while (!valid8 && edges < 30) begin
            tick();
            edges++;
            if (!valid8 && !busy8) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (q32 !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_q32 got %h want 0", q32); end
        n_cmp++; if (r32 !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_r32 got %h want 0", r32); end
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy32 got %b want 0", busy32); end
        n_cmp++; if (valid32 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid32 got %b want 0", valid32); end
        n_cmp++; if (dbz32 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_dbz32 got %b want 0", dbz32); end
        n_cmp++; if (q8 !== 8'h0 || busy8 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_dut8 got q=%h busy=%b want 0/0", q8, busy8); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_signed_neg();
        int   edges;
        logic bok;
        applyStimulus32(1'b1, 32'hFFFFFFF9, 32'h00000002, edges, bok);
        n_cmp++; if (edges !== 34) begin n_bad++; $display("[TB] FAIL neg_latency got %0d want 34", edges); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("[TB] FAIL neg_busy_hold got %b want 1", bok); end
        n_cmp++; if (busy32 !== 1'b0) begin n_bad++; $display("[TB] FAIL neg_busy_drop got %b want 0", busy32); end
        n_cmp++; if (q32 !== 32'hFFFFFFFD) begin n_bad++; $display("[TB] FAIL neg_q got %h want fffffffd", q32); end
        n_cmp++; if (r32 !== 32'hFFFFFFFF) begin n_bad++; $display("[TB] FAIL neg_r got %h want ffffffff", r32); end
        n_cmp++; if (dbz32 !== 1'b0) begin n_bad++; $display("[TB] FAIL neg_dbz got %b want 0", dbz32); end
        tick();
        n_cmp++; if (valid32 !== 1'b0 || q32 !== 32'hFFFFFFFD) begin n_bad++; $display("[TB] FAIL neg_pulse got valid=%b q=%h want 0/fffffffd", valid32, q32); end
    endtask

    task automatic test_unsigned_large();
        int   edges;
        logic bok;
        applyStimulus32(1'b0, 32'hFFFFFFFF, 32'h00000010, edges, bok);
        n_cmp++; if (edges !== 34) begin n_bad++; $display("[TB] FAIL udiv_latency got %0d want 34", edges); end
        n_cmp++; if (q32 !== 32'h0FFFFFFF) begin n_bad++; $display("[TB] FAIL udiv_q got %h want 0fffffff", q32); end
        n_cmp++; if (r32 !== 32'h0000000F) begin n_bad++; $display("[TB] FAIL udiv_r got %h want 0000000f", r32); end
        applyStimulus32(1'b1, 32'hFFFFFFFF, 32'h00000010, edges, bok);
        n_cmp++; if (edges !== 34) begin n_bad++; $display("[TB] FAIL sdiv_m1_latency got %0d want 34", edges); end
        n_cmp++; if (q32 !== 32'h0) begin n_bad++; $display("[TB] FAIL sdiv_m1_q got %h want 0", q32); end
        n_cmp++; if (r32 !== 32'hFFFFFFFF) begin n_bad++; $display("[TB] FAIL sdiv_m1_r got %h want ffffffff", r32); end
        tick();
    endtask

    task automatic test_div_zero();
        int   edges;
        logic bok;
        applyStimulus32(1'b1, 32'd5, 32'd0, edges, bok);
        n_cmp++; if (edges !== 1) begin n_bad++; $display("[TB] FAIL dz_latency got %0d want 1", edges); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("[TB] FAIL dz_busy got %b want 1", bok); end
        n_cmp++; if (q32 !== 32'hFFFFFFFF) begin n_bad++; $display("[TB] FAIL dz_q got %h want ffffffff", q32); end
        n_cmp++; if (r32 !== 32'd5) begin n_bad++; $display("[TB] FAIL dz_r got %h want 00000005", r32); end
        n_cmp++; if (dbz32 !== 1'b1) begin n_bad++; $display("[TB] FAIL dz_flag got %b want 1", dbz32); end
        tick();
    endtask

    task automatic test_overflow();
        int   edges;
        logic bok;
        applyStimulus32(1'b1, 32'h80000000, 32'hFFFFFFFF, edges, bok);
        n_cmp++; if (edges !== 1) begin n_bad++; $display("[TB] FAIL ovf_latency got %0d want 1", edges); end
        n_cmp++; if (q32 !== 32'h80000000) begin n_bad++; $display("[TB] FAIL ovf_q got %h want 80000000", q32); end
        n_cmp++; if (r32 !== 32'h0) begin n_bad++; $display("[TB] FAIL ovf_r got %h want 0", r32); end
        n_cmp++; if (dbz32 !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_dbz got %b want 0", dbz32); end
        tick();
    endtask

    task automatic test_ignore_flush_reset();
        int   edges;
        logic seen;
        sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd3; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        edges = 5;
        while (!valid32 && edges < 60) begin
            tick();
            edges++;
        end
        n_cmp++; if (edges !== 34) begin n_bad++; $display("[TB] FAIL ign_latency got %0d want 34", edges); end
        n_cmp++; if (q32 !== 32'd33) begin n_bad++; $display("[TB] FAIL ign_q got %0d want 33", q32); end
        n_cmp++; if (r32 !== 32'd1) begin n_bad++; $display("[TB] FAIL ign_r got %0d want 1", r32); end
        tick();

        a32 = 32'd77; b32 = 32'd8; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        flush32 = 1'b1;
        tick();
        flush32 = 1'b0;
        n_cmp++; if (busy32 !== 1'b0 || valid32 !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_busy got busy=%b valid=%b want 0/0", busy32, valid32); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid32 || busy32) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_novalid got %b want 0", seen); end
        n_cmp++; if (q32 !== 32'd33 || r32 !== 32'd1) begin n_bad++; $display("[TB] FAIL flush_hold got %0d/%0d want 33/1", q32, r32); end

        a32 = 32'd200; b32 = 32'd9; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (q32 !== 32'h0 || r32 !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_mid_qr got %h/%h want 0/0", q32, r32); end
        n_cmp++; if (busy32 !== 1'b0 || valid32 !== 1'b0 || dbz32 !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_ctl got busy=%b valid=%b dbz=%b want 0", busy32, valid32, dbz32); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int   edges;
        logic bok;
        applyStimulus8(1'b0, 8'd200, 8'd7, edges, bok);
        n_cmp++; if (edges !== 10) begin n_bad++; $display("[TB] FAIL w8_latency got %0d want 10", edges); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("[TB] FAIL w8_busy got %b want 1", bok); end
        n_cmp++; if (q8 !== 8'd28) begin n_bad++; $display("[TB] FAIL w8_q got %0d want 28", q8); end
        n_cmp++; if (r8 !== 8'd4) begin n_bad++; $display("[TB] FAIL w8_r got %0d want 4", r8); end
        applyStimulus8(1'b1, 8'h80, 8'hFF, edges, bok);
        n_cmp++; if (edges !== 1) begin n_bad++; $display("[TB] FAIL b2b_latency got %0d want 1", edges); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_accept got %b want 1", bok); end
        n_cmp++; if (q8 !== 8'h80 || r8 !== 8'h00) begin n_bad++; $display("[TB] FAIL b2b_qr got %h/%h want 80/00", q8, r8); end
        n_cmp++; if (dbz8 !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_dbz got %b want 0", dbz8); end
        tick();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        start32 = 1'b0; flush32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; flush8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
        test_reset();
        test_signed_neg();
        test_unsigned_large();
        test_div_zero();
        test_overflow();
        test_ignore_flush_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised iterative integer divider for the RV32M execute stage; successor to the fixed 32-bit divider.
- Supports signed and unsigned operation and returns quotient and remainder together, covering DIV/DIVU/REM/REMU.
- Uses an explicit start/busy/valid handshake, a pipeline flush input, and a fast path for RISC-V special cases.
- Sits beside the ALU; the pipeline stalls while busy=1.

Parameters:
- WIDTH, 32: operand and result width in bits; legal values are >= 2.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- flush  input  1  abort the in-flight operation.
- op_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high from the accepting edge until the result edge.
- valid  output  1  one-cycle pulse when results are updated.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- div_by_zero  output  1  registered flag, qualified by valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, valid, div_by_zero = 0.
  - quotient, remainder = 0.
  - Internal operand, counter and sign registers = 0.
  - Takes effect immediately, including mid-operation; no partial result is ever emitted.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at edge E0: operands and op_signed are latched, busy=1.
  - Divisor == 0: go to DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
  - op_signed=1 with dividend = 1 followed by WIDTH-1 zeros (MIN) and divisor = all ones: go to DONE with quotient = MIN, remainder = 0, div_by_zero=0.
  - Otherwise: latch |dividend| and |divisor| (negate only when op_signed=1 and the MSB is set), latch q_neg = signs differ and r_neg = dividend sign (both 0 when unsigned), clear the partial remainder, load counter = WIDTH, go to CALC.
- CALC (one restoring step per cycle):
  - Shift {rem, dq} left by 1.
  - trial = rem_shifted - |divisor|, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial and the quotient LSB = 1; else the quotient LSB = 0.
  - Counter decrements; leave CALC when it reaches 1 (exactly WIDTH iterations).
- FIX: apply sign correction: quotient = q_neg ? -q : q, remainder = r_neg ? -r : r; go to DONE.
- DONE: valid=1 for exactly one cycle, busy deasserts on the same edge, return to IDLE.
- Latency, counted from the accepting edge E0:
  - Normal path: valid is high in the cycle after edge E(WIDTH+2).
  - Special path: valid is high in the cycle after edge E1.
  - A back-to-back start is accepted on the cycle valid is high; state is IDLE there, so this adds zero bubbles.
- Output stability: quotient, remainder and div_by_zero change only on the edge that raises valid, then hold until the next such edge.
- Handshake rules:
  - start while busy=1 is ignored; operands are not re-sampled.
  - flush=1 in CALC or FIX: go to IDLE next edge, busy=0, no valid, outputs retain previous values.
  - flush=1 in IDLE or DONE has no effect.
  - flush and start together in IDLE: flush is ignored and start is accepted.
- Remainder sign always follows the dividend (truncating division).
- Identity to hold: dividend == quotient*divisor + remainder, mod 2^WIDTH, for every non-zero divisor including the overflow case.

Decomposition:
- Shared package div_pkg:
  - State enum constants (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3).
  - Helper constant function for CNT_W.
- One natural sub-module, div_step:
  - Combinational single restoring iteration, parametrised by WIDTH.
  - Inputs rem, dq, divisor; outputs next rem and next dq.
  - Instantiated once inside div_unit's CALC datapath.
- Sign handling, the special-case fast path and the FSM stay in div_unit.

Test Plan:
- WIDTH=32, signed, -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, valid in the cycle after E34, busy high E0..E34.
- WIDTH=32, unsigned, 0xFFFFFFFF / 0x00000010 -> quotient=0x0FFFFFFF, remainder=0x0000000F; the same operands with op_signed=1 -> quotient=0, remainder=0xFFFFFFFF.
- Divide by zero, signed, 5 / 0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, valid in the cycle after E1.
- Overflow, signed, 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0, valid after E1.
- Start 100/3, then:
  - Pulse start with other operands at E5: ignored; the result is still 33 rem 1.
  - Flush at E10 of a second operation: busy=0 after E11, no valid pulse, outputs still 33/1.
  - Drive reset low mid-CALC: all outputs are 0 immediately.
- WIDTH=8, unsigned, 200 / 7 -> quotient=28, remainder=4, valid after E10; back-to-back start on the valid cycle with 0x80 / 0xFF signed -> quotient=0x80, remainder=0.
